// File: rtl/key_hex_counter.sv
// rtl/key_hex_counter.sv - debounced three-key 4-bit hex counter with load and wrap flag

module key_press #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int            CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] deb_cnt;

    // Two-flop synchronizer; idle (released) level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a level change only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable  <= 1'b1;
            deb_cnt <= '0;
        end else if (sync2 == stable) begin
            deb_cnt <= '0;
        end else if (deb_cnt == LAST) begin
            stable  <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CW'(1);
        end
    end

    // One-cycle pulse on the accepted 1->0 transition only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= 1'b1;
            press    <= 1'b0;
        end else begin
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

endmodule

module key_hex_counter #(
    parameter int         DEB_CYCLES = 1000000,
    parameter logic [3:0] INIT       = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       key_ld_n,
    input  logic [3:0] sw,
    output logic [3:0] cnt,
    output logic       wrap,
    output logic       evt
);

    logic up_press;
    logic dn_press;
    logic ld_press;

    key_press #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_up_n),
        .press (up_press)
    );

    key_press #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_dn_n),
        .press (dn_press)
    );

    key_press #(.DEB_CYCLES(DEB_CYCLES)) u_ld (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_ld_n),
        .press (ld_press)
    );

    // Count update: load beats everything, up+down together cancel, flags pulse for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= INIT;
            wrap <= 1'b0;
            evt  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            evt  <= 1'b0;
            if (ld_press) begin
                cnt <= sw;
                evt <= 1'b1;
            end else if (up_press && dn_press) begin
                cnt <= cnt;
            end else if (up_press) begin
                cnt  <= cnt + 4'h1;
                wrap <= (cnt == 4'hF);
                evt  <= 1'b1;
            end else if (dn_press) begin
                cnt  <= cnt - 4'h1;
                wrap <= (cnt == 4'h0);
                evt  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_hex_counter.sv
// tb/tb_key_hex_counter.sv - self-checking bench for key_hex_counter

module tb_key_hex_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_up_n;
    logic       key_dn_n;
    logic       key_ld_n;
    logic [3:0] sw;
    logic [3:0] cnt;
    logic       wrap;
    logic       evt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] c;
        logic       w;
    } exp_t;

    typedef struct {
        bit         up;
        bit         dn;
        bit         ld;
        logic [3:0] sw;
        int         hold;
        bit         exp_evt;
        logic [3:0] exp_cnt;
        bit         exp_wrap;
    } vec_t;

    exp_t sb[$];

    key_hex_counter #(.DEB_CYCLES(4), .INIT(4'h0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .key_ld_n (key_ld_n),
        .sw       (sw),
        .cnt      (cnt),
        .wrap     (wrap),
        .evt      (evt)
    );

    always #5 clk = ~clk;

    // Scoreboard: every evt pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (evt === 1'b1) begin
                exp_t e;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_evt: cnt=%h wrap=%b, no event expected", cnt, wrap);
                end else begin
                    e = sb.pop_front();
                    if (cnt !== e.c || wrap !== e.w) begin
                        errors++;
                        $display("FAIL evt_result: cnt=%h wrap=%b, expected cnt=%h wrap=%b", cnt, wrap, e.c, e.w);
                    end
                end
            end else if (wrap !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL wrap_without_evt: wrap=%b, expected 0", wrap);
            end
        end
    end

    task automatic run_vec(input vec_t v, input string name);
        logic [3:0] start;
        int         first;
        int         exp_lat;
        if (v.exp_evt) sb.push_back('{c: v.exp_cnt, w: v.exp_wrap});
        @(negedge clk);
        sw       = v.sw;
        key_up_n = ~v.up;
        key_dn_n = ~v.dn;
        key_ld_n = ~v.ld;
        start    = cnt;
        first    = -1;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            if (first < 0 && cnt !== start) first = i;
        end
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        key_ld_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        exp_lat = v.exp_evt ? 7 : -1;
        checks++;
        if (first != exp_lat) begin
            errors++;
            $display("FAIL %s latency: first change at edge %0d, expected %0d", name, first, exp_lat);
        end
        checks++;
        if (cnt !== v.exp_cnt) begin
            errors++;
            $display("FAIL %s cnt: got %h, expected %h", name, cnt, v.exp_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s evt_missing: %0d pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vec_t       tbl[$];
        vec_t       v;
        logic [3:0] model;

        rst_n    = 1'b0;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        key_ld_n = 1'b1;
        sw       = 4'h0;

        // Reset state held, then 10 quiet cycles after release
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'h0 || wrap !== 1'b0 || evt !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cnt=%h wrap=%b evt=%b, expected 0 0 0", cnt, wrap, evt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt !== 4'h0 || wrap !== 1'b0 || evt !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: cnt=%h wrap=%b evt=%b, expected 0 0 0", cnt, wrap, evt);
            end
        end

        // Sixteen clean up presses: 1..F then wrap to 0
        model = 4'h0;
        for (int k = 0; k < 16; k++) begin
            v = '{up: 1'b1, dn: 1'b0, ld: 1'b0, sw: 4'h0, hold: 20,
                  exp_evt: 1'b1, exp_cnt: model + 4'h1, exp_wrap: (model == 4'hF)};
            run_vec(v, "up_step");
            model = model + 4'h1;
        end

        // Bounce on the down key must be rejected
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            key_dn_n = ~key_dn_n;
            repeat (2) @(negedge clk);
        end
        key_dn_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'h0) begin
            errors++;
            $display("FAIL bounce_cnt: got %h, expected 0", cnt);
        end

        // Table of single presses and corner combinations
        tbl.push_back('{up: 1'b0, dn: 1'b1, ld: 1'b0, sw: 4'h0, hold: 20, exp_evt: 1'b1, exp_cnt: 4'hF, exp_wrap: 1'b1});
        tbl.push_back('{up: 1'b0, dn: 1'b0, ld: 1'b1, sw: 4'hA, hold: 20, exp_evt: 1'b1, exp_cnt: 4'hA, exp_wrap: 1'b0});
        tbl.push_back('{up: 1'b1, dn: 1'b0, ld: 1'b1, sw: 4'h3, hold: 20, exp_evt: 1'b1, exp_cnt: 4'h3, exp_wrap: 1'b0});
        tbl.push_back('{up: 1'b0, dn: 1'b0, ld: 1'b1, sw: 4'h5, hold: 20, exp_evt: 1'b1, exp_cnt: 4'h5, exp_wrap: 1'b0});
        tbl.push_back('{up: 1'b1, dn: 1'b1, ld: 1'b0, sw: 4'h0, hold: 20, exp_evt: 1'b0, exp_cnt: 4'h5, exp_wrap: 1'b0});
        tbl.push_back('{up: 1'b1, dn: 1'b0, ld: 1'b0, sw: 4'h0, hold: 200, exp_evt: 1'b1, exp_cnt: 4'h6, exp_wrap: 1'b0});
        tbl.push_back('{up: 1'b0, dn: 1'b1, ld: 1'b1, sw: 4'h0, hold: 20, exp_evt: 1'b1, exp_cnt: 4'h0, exp_wrap: 1'b0});
        tbl.push_back('{up: 1'b0, dn: 1'b1, ld: 1'b0, sw: 4'h0, hold: 20, exp_evt: 1'b1, exp_cnt: 4'hF, exp_wrap: 1'b1});
        tbl.push_back('{up: 1'b0, dn: 1'b1, ld: 1'b0, sw: 4'h0, hold: 20, exp_evt: 1'b1, exp_cnt: 4'hE, exp_wrap: 1'b0});
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-run: outputs clear without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt !== 4'h0 || wrap !== 1'b0 || evt !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%h wrap=%b evt=%b, expected 0 0 0", cnt, wrap, evt);
        end

        // Key held through reset release is a fresh press
        key_up_n = 1'b0;
        repeat (3) @(posedge clk);
        sb.push_back('{c: 4'h1, w: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        key_up_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (cnt !== 4'h1 || sb.size() != 0) begin
            errors++;
            $display("FAIL held_through_reset: cnt=%h pending=%0d, expected cnt=1 pending=0", cnt, sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
